uart_rx_datapath: RTL and testbench

UART_RX_DATAPATH -- requirements
Module: uart_rx_datapath

---
 rtl/uart_pkg.sv | 8 +
 rtl/uart_rx_sync.sv | 30 +++
 rtl/uart_rx_datapath.sv | 105 ++++++++++
 tb/tb_uart_rx_datapath.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: default frame width, parity modes
// and the idle level of the serial line.
package uart_pkg;
    localparam int   DATA_BITS_DEFAULT = 8;
    localparam logic PARITY_EVEN       = 1'b0;
    localparam logic PARITY_ODD        = 1'b1;
    localparam logic LINE_IDLE         = 1'b1;
endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line. Both flops reset to
// the idle line level so that no false start bit is seen coming out of reset.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta_q <= LINE_IDLE;
            sync_q <= LINE_IDLE;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/uart_rx_datapath.sv
// UART receive datapath: start detect, LSB-first shifter, parity/stop checks and
// a one-deep output holding register. Define UART_RX_SYNC_EN to add a line synchronizer.
module uart_rx_datapath #(
    parameter int   DATA_BITS  = uart_pkg::DATA_BITS_DEFAULT,
    parameter logic PARITY_ODD = 1'b0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx_in,
    input  logic                 rx_shift,
    input  logic                 parity_load,
    input  logic                 check_stop,
    input  logic                 data_ready,
    output logic                 start_detect,
    output logic                 parity_error,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_valid,
    output logic                 framing_error,
    output logic                 overrun
);
    logic rx_s;

`ifdef UART_RX_SYNC_EN
    uart_rx_sync u_sync (
        .clock (clock),
        .reset (reset),
        .d     (rx_in),
        .q     (rx_s)
    );
`else
    assign rx_s = rx_in;
`endif

    logic                 idle_q, idle_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 overrun_q, overrun_d;
    logic                 slot_free;

    always_comb begin
        start_detect = idle_q & ~rx_s;
        parity_error = parity_load & ((^shift_q) ^ rx_s ^ PARITY_ODD);
        // The holding register is free if empty or being consumed this very edge.
        slot_free    = ~valid_q | data_ready;

        idle_d    = idle_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ferr_d    = 1'b0;
        overrun_d = overrun_q;

        if (check_stop || parity_error) begin
            idle_d = 1'b1;
        end else if (start_detect) begin
            idle_d = 1'b0;
        end

        if (rx_shift) begin
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
        end

        if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end

        if (check_stop) begin
            if (rx_s) begin
                if (slot_free) begin
                    data_d  = shift_q;
                    valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end else begin
                ferr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idle_q    <= 1'b1;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            idle_q    <= idle_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            overrun_q <= overrun_d;
        end
    end

    assign rx_data       = data_q;
    assign data_valid    = valid_q;
    assign framing_error = ferr_q;
    assign overrun       = overrun_q;
endmodule

// File: tb/tb_uart_rx_datapath.sv
// Self-checking bench for uart_rx_datapath: the bench plays the receive controller
// and predicts results from a frame-level model (even parity, 8 data bits).
module tb_uart_rx_datapath;
`ifdef UART_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       rx_in, rx_shift, parity_load, check_stop, data_ready;
    logic       start_detect, parity_error, data_valid, framing_error, overrun;
    logic [7:0] rx_data;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_data;
    bit         m_valid;
    bit         m_overrun;

    uart_rx_datapath #(.DATA_BITS(8), .PARITY_ODD(1'b0)) dut (
        .clock         (clock),
        .reset         (reset),
        .rx_in         (rx_in),
        .rx_shift      (rx_shift),
        .parity_load   (parity_load),
        .check_stop    (check_stop),
        .data_ready    (data_ready),
        .start_detect  (start_detect),
        .parity_error  (parity_error),
        .rx_data       (rx_data),
        .data_valid    (data_valid),
        .framing_error (framing_error),
        .overrun       (overrun)
    );

    always #5 clock = ~clock;

    // Reset is asserted at a negedge and checked before any clock edge.
    task automatic test_reset(input string tag);
        @(negedge clock);
        reset = 1'b0; rx_in = 1'b1; rx_shift = 1'b0; parity_load = 1'b0;
        check_stop = 1'b0; data_ready = 1'b0;
        #1;
        checks++;
        if (data_valid !== 1'b0 || rx_data !== 8'h00 || framing_error !== 1'b0 ||
            overrun !== 1'b0 || start_detect !== 1'b0 || parity_error !== 1'b0) begin
            errors++;
            $display("FAIL %s reset_values: valid=%b data=%h ferr=%b ovr=%b sd=%b perr=%b required 0 00 0 0 0 0",
                     tag, data_valid, rx_data, framing_error, overrun, start_detect, parity_error);
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        m_valid = 1'b0; m_data = 8'h00; m_overrun = 1'b0;
        $display("reset %s done", tag);
    endtask

    // One complete frame as the controller would sequence it; a bad-parity frame
    // ends after the parity cycle because the controller returns to idle.
    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                              input bit rdy, input logic tail, input string tag);
        logic line [0:10];
        int   n, k;
        bit   v_at_stop, load, exp_sd, exp_ferr, exp_valid;

        line[0] = 1'b0;
        for (int i = 0; i < 8; i++) line[1+i] = d[i];
        line[9]  = ($countones(d) % 2 == 1) ^ bad_par;
        line[10] = ~bad_stop;
        n = bad_par ? 10 : 11;
        data_ready = rdy;
        v_at_stop  = m_valid && !rdy;

        for (int t = 0; t < n + LAT; t++) begin
            @(negedge clock);
            rx_in = (t < n) ? line[t] : tail;
            k = t - LAT;
            rx_shift    = (k >= 1 && k <= 8);
            parity_load = (k == 9);
            check_stop  = (k == 10);
            #1;
            exp_sd = (k == 0);
            checks++;
            if (start_detect !== exp_sd) begin
                errors++;
                $display("FAIL %s start_detect k=%0d: got %b required %b", tag, k, start_detect, exp_sd);
            end
            if (k == 9) begin
                checks++;
                if (parity_error !== bad_par) begin
                    errors++;
                    $display("FAIL %s parity_error: got %b required %b", tag, parity_error, bad_par);
                end
            end
        end

        load = !bad_par && !bad_stop && !v_at_stop;
        if (!bad_par && !bad_stop && v_at_stop) m_overrun = 1'b1;
        if (load) m_data = d;
        m_valid  = v_at_stop || load;
        exp_ferr = !bad_par && bad_stop;

        @(negedge clock);
        checks++;
        if (data_valid !== m_valid || rx_data !== m_data || overrun !== m_overrun ||
            framing_error !== exp_ferr) begin
            errors++;
            $display("FAIL %s after_frame: valid=%b data=%h ovr=%b ferr=%b required %b %h %b %b",
                     tag, data_valid, rx_data, overrun, framing_error, m_valid, m_data, m_overrun, exp_ferr);
        end
        rx_shift = 1'b0; parity_load = 1'b0; check_stop = 1'b0; rx_in = tail;
        #1;
        if (tail == 1'b0) begin
            checks++;
            if (start_detect !== 1'b1) begin
                errors++;
                $display("FAIL %s break_restart: start_detect=%b required 1", tag, start_detect);
            end
        end

        exp_valid = m_valid && !rdy;
        @(negedge clock);
        checks++;
        if (data_valid !== exp_valid || framing_error !== 1'b0 || rx_data !== m_data) begin
            errors++;
            $display("FAIL %s settle: valid=%b ferr=%b data=%h required %b 0 %h",
                     tag, data_valid, framing_error, rx_data, exp_valid, m_data);
        end
        m_valid = exp_valid;
        $display("frame %s data=%h bad_par=%0d bad_stop=%0d ready=%0d -> rx_data=%h valid=%b ovr=%b",
                 tag, d, bad_par, bad_stop, rdy, rx_data, data_valid, overrun);
    endtask

    task automatic test_basic();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, "a5_good");
    endtask

    task automatic test_parity();
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, "a5_badpar");
    endtask

    task automatic test_framing();
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1'b1, "3c_badstop");
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b1, "55_after_ferr");
    endtask

    task automatic test_overrun();
        send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, "11_hold");
        send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, "22_overrun");
        @(negedge clock);
        data_ready = 1'b1;
        @(negedge clock);
        data_ready = 1'b0;
        m_valid = 1'b0;
        checks++;
        if (data_valid !== 1'b0 || overrun !== 1'b1 || rx_data !== 8'h11) begin
            errors++;
            $display("FAIL overrun_consume: valid=%b ovr=%b data=%h required 0 1 11",
                     data_valid, overrun, rx_data);
        end
        $display("consume after overrun: valid=%b ovr=%b data=%h", data_valid, overrun, rx_data);
    endtask

    task automatic test_break();
        send_frame(8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, "break_badpar");
        test_reset("after_break");
    endtask

    task automatic test_reset_midframe();
        int k;
        for (int t = 0; t < 5 + LAT; t++) begin
            @(negedge clock);
            rx_in = (t == 0) ? 1'b0 : 1'b1;
            k = t - LAT;
            rx_shift = (k >= 1 && k <= 4);
        end
        test_reset("midframe");
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b1, "81_after_reset");
    endtask

    task automatic test_random();
        logic [7:0] d;
        bit bp, bs, rdy;
        for (int i = 0; i < 24; i++) begin
            d   = 8'($urandom_range(0, 255));
            bp  = ($urandom_range(0, 5) == 0);
            bs  = ($urandom_range(0, 5) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            send_frame(d, bp, bs, rdy, 1'b1, "rand");
        end
    endtask

    initial begin
        reset = 1'b1; rx_in = 1'b1; rx_shift = 1'b0; parity_load = 1'b0;
        check_stop = 1'b0; data_ready = 1'b0;
        m_valid = 1'b0; m_data = 8'h00; m_overrun = 1'b0;
        test_reset("initial");
        test_basic();
        test_parity();
        test_framing();
        test_overrun();
        test_break();
        test_reset_midframe();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
